// File: rtl/fp_add.sv
// IEEE 754 binary32 adder: combinational sum plus a one-cycle registered copy.
// Round-to-nearest-even, gradual underflow, canonical quiet NaN, no flags.
module fp_add (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s,
  output logic [31:0] s_reg,
  output logic        s_valid
);

  // Leading-zero count of a 27-bit significand (27 when all zero).
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  logic        a_nan_s, b_nan_s, a_inf_s, b_inf_s;
  logic        swap_s, sub_s;
  logic [31:0] big_s, small_s;
  logic [7:0]  eb_s, es_s, diff_s, limit_s, shamt_s;
  logic [23:0] mb_s, ms_s;
  logic [49:0] shifted_s;
  logic [26:0] aligned_s, norm_s;
  logic [27:0] sum_s;
  logic [4:0]  lz_s;
  logic [9:0]  exp_n_s, exp_f_s;
  logic        round_up_s;
  logic [24:0] mant_r_s;
  logic [22:0] frac_s;

  assign a_nan_s = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan_s = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  assign a_inf_s = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
  assign b_inf_s = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);

  // Order operands by magnitude so the subtraction never goes negative.
  assign swap_s  = b[30:0] > a[30:0];
  assign big_s   = swap_s ? b : a;
  assign small_s = swap_s ? a : b;
  assign sub_s   = a[31] ^ b[31];

  assign eb_s   = (big_s[30:23] == 8'd0)   ? 8'd1 : big_s[30:23];
  assign es_s   = (small_s[30:23] == 8'd0) ? 8'd1 : small_s[30:23];
  assign mb_s   = {(big_s[30:23] != 8'd0), big_s[22:0]};
  assign ms_s   = {(small_s[30:23] != 8'd0), small_s[22:0]};
  assign diff_s = eb_s - es_s;

  // Align, add, normalize, round and select the special-case result.
  always_comb begin
    shifted_s  = {ms_s, 26'd0} >> diff_s;
    aligned_s  = 27'd0;
    sum_s      = 28'd0;
    lz_s       = 5'd0;
    limit_s    = eb_s - 8'd1;
    shamt_s    = 8'd0;
    norm_s     = 27'd0;
    exp_n_s    = 10'd0;
    exp_f_s    = 10'd0;
    round_up_s = 1'b0;
    mant_r_s   = 25'd0;
    frac_s     = 23'd0;
    s          = 32'd0;

    // Layout of aligned_s: 24-bit significand, guard, round, sticky.
    if (diff_s >= 8'd26) begin
      aligned_s = {26'd0, |ms_s};
    end else begin
      aligned_s = {shifted_s[49:24], |shifted_s[23:0]};
    end

    if (sub_s) begin
      sum_s = {1'b0, mb_s, 3'b000} - {1'b0, aligned_s};
    end else begin
      sum_s = {1'b0, mb_s, 3'b000} + {1'b0, aligned_s};
    end

    lz_s = lzc27(sum_s[26:0]);
    if (sum_s[27]) begin
      norm_s  = {sum_s[27:2], sum_s[1] | sum_s[0]};
      exp_n_s = {2'b00, eb_s} + 10'd1;
    end else begin
      // Cap the left shift so the exponent stops at 1 (gradual underflow).
      shamt_s = ({3'b000, lz_s} > limit_s) ? limit_s : {3'b000, lz_s};
      norm_s  = sum_s[26:0] << shamt_s;
      exp_n_s = {2'b00, eb_s} - {2'b00, shamt_s};
    end

    if (!norm_s[26]) begin
      exp_n_s = 10'd0;
    end else begin
      exp_n_s = exp_n_s;
    end

    round_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
    mant_r_s   = {1'b0, norm_s[26:3]} + {24'd0, round_up_s};

    if (mant_r_s[24]) begin
      exp_f_s = exp_n_s + 10'd1;
      frac_s  = mant_r_s[23:1];
    end else if ((exp_n_s == 10'd0) && mant_r_s[23]) begin
      exp_f_s = 10'd1;
      frac_s  = mant_r_s[22:0];
    end else begin
      exp_f_s = exp_n_s;
      frac_s  = mant_r_s[22:0];
    end

    if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && sub_s)) begin
      s = 32'h7FC0_0000;
    end else if (a_inf_s) begin
      s = a;
    end else if (b_inf_s) begin
      s = b;
    end else if (sum_s == 28'd0) begin
      s = {(~sub_s) & big_s[31], 31'd0};
    end else if (exp_f_s >= 10'd255) begin
      s = {big_s[31], 8'hFF, 23'd0};
    end else begin
      s = {big_s[31], exp_f_s[7:0], frac_s};
    end
  end

  // Registered copy of the sum for pipelined consumers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_reg   <= 32'd0;
      s_valid <= 1'b0;
    end else begin
      s_reg   <= s;
      s_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_add.sv
// Scoreboard bench for fp_add: directed vectors, expected sums queued at issue,
// monitors compare the combinational and registered outputs independently.
module tb_fp_add;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic [31:0] s, s_reg;
  logic        s_valid;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          idx;
    logic [31:0] exp;
  } exp_t;

  exp_t comb_q[$];
  exp_t reg_q[$];

  fp_add dut (
    .clk     (clk),
    .reset   (reset),
    .a       (a),
    .b       (b),
    .s       (s),
    .s_reg   (s_reg),
    .s_valid (s_valid)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int idx,
                                input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %08h expected %08h", name, idx, act, exp);
    end
  endfunction

  // Combinational result checked mid-cycle, after inputs settle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (comb_q.size() > 0) begin
        e = comb_q.pop_front();
        check("s", e.idx, s, e.exp);
      end
    end
  end

  // Registered result checked just after the capturing edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (s_valid === 1'b1 && reg_q.size() > 0) begin
        e = reg_q.pop_front();
        check("s_reg", e.idx, s_reg, e.exp);
      end
    end
  end

  logic [31:0] va[17];
  logic [31:0] vb[17];
  logic [31:0] ve[17];

  task automatic issue(input int idx);
    exp_t e;
    a = va[idx];
    b = vb[idx];
    e.idx = idx;
    e.exp = ve[idx];
    comb_q.push_back(e);
    reg_q.push_back(e);
  endtask

  initial begin
    va[0]  = 32'h3F80_0000; vb[0]  = 32'h4000_0000; ve[0]  = 32'h4040_0000;
    va[1]  = 32'h3F80_0000; vb[1]  = 32'h3F80_0000; ve[1]  = 32'h4000_0000;
    va[2]  = 32'h3FC0_0000; vb[2]  = 32'h4010_0000; ve[2]  = 32'h4070_0000;
    va[3]  = 32'h3F80_0000; vb[3]  = 32'hBF80_0000; ve[3]  = 32'h0000_0000;
    va[4]  = 32'h8000_0000; vb[4]  = 32'h8000_0000; ve[4]  = 32'h8000_0000;
    va[5]  = 32'h0000_0000; vb[5]  = 32'h8000_0000; ve[5]  = 32'h0000_0000;
    va[6]  = 32'h3F80_0000; vb[6]  = 32'h3380_0000; ve[6]  = 32'h3F80_0000;
    va[7]  = 32'h3F80_0000; vb[7]  = 32'h33C0_0000; ve[7]  = 32'h3F80_0001;
    va[8]  = 32'h7F7F_FFFF; vb[8]  = 32'h7F7F_FFFF; ve[8]  = 32'h7F80_0000;
    va[9]  = 32'h0000_0001; vb[9]  = 32'h0000_0001; ve[9]  = 32'h0000_0002;
    va[10] = 32'h0040_0000; vb[10] = 32'h0040_0000; ve[10] = 32'h0080_0000;
    va[11] = 32'h7F80_0000; vb[11] = 32'hFF80_0000; ve[11] = 32'h7FC0_0000;
    va[12] = 32'h7FC0_0001; vb[12] = 32'h3F80_0000; ve[12] = 32'h7FC0_0000;
    va[13] = 32'hFF80_0000; vb[13] = 32'h3F80_0000; ve[13] = 32'hFF80_0000;
    va[14] = 32'h3F80_0000; vb[14] = 32'hB380_0000; ve[14] = 32'h3F7F_FFFF;
    va[15] = 32'hC020_0000; vb[15] = 32'h3F80_0000; ve[15] = 32'hBFC0_0000;
    va[16] = 32'h0080_0000; vb[16] = 32'h8000_0001; ve[16] = 32'h007F_FFFF;

    reset = 1'b1;
    a = 32'h3F80_0000;
    b = 32'h3F80_0000;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("reset_s_reg", i, s_reg, 32'h0000_0000);
      check("reset_s_valid", i, {31'd0, s_valid}, 32'd0);
    end

    #1;
    reset = 1'b0;
    issue(0);
    for (int i = 1; i < 17; i++) begin
      @(posedge clk);
      #2;
      issue(i);
    end

    for (int t = 0; t < 10 && (reg_q.size() > 0 || comb_q.size() > 0); t++) begin
      @(posedge clk);
    end
    if (reg_q.size() > 0 || comb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending expected 0", reg_q.size() + comb_q.size());
    end

    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rereset_s_reg", 0, s_reg, 32'h0000_0000);
    check("rereset_s_valid", 0, {31'd0, s_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_add.md
Name: fp_add

Overview:
- IEEE 754 single-precision (binary32) adder: s = a + b.
- Primary result path is purely combinational; the result must settle within the same clock cycle as the operand change.
- A registered copy of the result is also provided for pipelined consumers.
- Sits in the ALU datapath alongside the integer units.

Parameters:
- None.

Ports:
- clk  input  1  system clock; rising-edge active.
- reset  input  1  synchronous, active-high reset; affects only the registered outputs.
- a  input  32  operand A, binary32 (bit 31 sign, 30:23 exponent, 22:0 fraction).
- b  input  32  operand B, binary32.
- s  output  32  combinational sum a+b, binary32.
- s_reg  output  32  s captured on each rising clk edge.
- s_valid  output  1  high once s_reg holds a sum captured outside reset.

Behaviour:
- Combinational path: s is a pure function of a and b, with no dependence on clk or reset. It must be stable well under half a clock period after the inputs change.
- Unpack:
  - Hidden bit = 1 for normal numbers (exp != 0) and 0 for subnormals (exp == 0).
  - Subnormals use effective exponent 1.
- Align: swap so the larger-magnitude operand is first (compare {exp, frac}), then right-shift the smaller significand by the exponent difference.
  - Keep guard, round and sticky bits; sticky is the OR of all bits shifted past round.
  - Shifts of 26 or more leave only sticky.
- Add or subtract significands according to the XOR of the signs. The result sign is the sign of the larger-magnitude operand.
- Normalize:
  - On carry-out, shift right 1 and increment the exponent.
  - Otherwise left-shift by the leading-zero count, limited so the exponent does not go below 1 (gradual underflow: the result becomes subnormal, exp field 0).
- Rounding is round-to-nearest, ties-to-even, using guard/round/sticky. A rounding carry that overflows the significand increments the exponent.
- Overflow: an exponent of 255 or more after rounding produces signed infinity (0x7F800000 / 0xFF800000).
- Exact zero results:
  - x + (-x) gives +0 (0x00000000).
  - (-0) + (-0) gives -0 (0x80000000).
  - (+0) + (-0) gives +0.
- Specials:
  - Any NaN input gives the canonical quiet NaN 0x7FC00000.
  - +inf + -inf gives 0x7FC00000.
  - inf + finite gives that inf.
  - inf + same-sign inf gives that inf.
- No exception flags are produced.
- Registered path, on each rising clk edge:
  - If reset is high: s_reg <= 0x00000000 and s_valid <= 0.
  - Otherwise: s_reg <= s and s_valid <= 1.
  - Latency is 1 cycle.
  - Asserting reset mid-stream clears both registered outputs on the next edge.
  - The first valid s_reg appears on the first edge with reset low.
- Output bits are never X or Z for any 0/1 input combination.

Test Plan:
- 3F800000 + 3F800000 -> s = 40000000 (1+1=2); 3FC00000 + 40100000 -> s = 40700000 (1.5+2.25=3.75).
- 3F800000 + BF800000 -> s = 00000000; 80000000 + 80000000 -> s = 80000000.
- Rounding cases:
  - 3F800000 + 33800000 (exact tie) -> s = 3F800000 (tie to even).
  - 3F800000 + 33C00000 -> s = 3F800001 (round up).
- Overflow and subnormals:
  - 7F7FFFFF + 7F7FFFFF -> s = 7F800000.
  - 00000001 + 00000001 -> s = 00000002.
  - 00400000 + 00400000 -> s = 00800000 (subnormal to normal).
- Specials:
  - 7F800000 + FF800000 -> s = 7FC00000.
  - 7FC00001 + 3F800000 -> s = 7FC00000.
  - FF800000 + 3F800000 -> s = FF800000.
- Registered path:
  - With reset=1 for 10 cycles: s_reg = 0 and s_valid = 0.
  - After release, apply a=3F800000, b=40000000: one edge later s_reg = 40400000 and s_valid = 1.
  - Reassert reset: next edge returns s_reg = 0 and s_valid = 0.
